// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU decode/execute slice.
// Holds opcode constants, the controller state enum, ALU operation codes,
// flag bit positions, memory-map bounds and small opcode-classification
// helpers used by decode_execute_unit and alu8.
package cpu_pkg;

    // Load / store opcodes
    localparam logic [7:0] YUKLE_A_SBT     = 8'h86;
    localparam logic [7:0] YUKLE_A         = 8'h87;
    localparam logic [7:0] YUKLE_B_SBT     = 8'h88;
    localparam logic [7:0] YUKLE_B         = 8'h89;
    localparam logic [7:0] KAYDET_A        = 8'h96;
    localparam logic [7:0] KAYDET_B        = 8'h97;
    // ALU opcodes
    localparam logic [7:0] TOPLA_AB        = 8'h42;
    localparam logic [7:0] CIKAR_AB        = 8'h43;
    localparam logic [7:0] VE_AB           = 8'h44;
    localparam logic [7:0] VEYA_AB         = 8'h45;
    localparam logic [7:0] ARTIR_A         = 8'h46;
    localparam logic [7:0] ARTIR_B         = 8'h47;
    localparam logic [7:0] AZALT_A         = 8'h48;
    localparam logic [7:0] AZALT_B         = 8'h49;
    // Branch opcodes
    localparam logic [7:0] ATLA            = 8'h20;
    localparam logic [7:0] ATLA_N          = 8'h21;
    localparam logic [7:0] ATLA_N_DEGIL    = 8'h22;
    localparam logic [7:0] ATLA_Z          = 8'h23;
    localparam logic [7:0] ATLA_Z_DEGIL    = 8'h24;
    localparam logic [7:0] ATLA_V          = 8'h25;
    localparam logic [7:0] ATLA_V_DEGIL    = 8'h26;
    localparam logic [7:0] ATLA_C          = 8'h27;
    localparam logic [7:0] ATLA_ELDE_YOKSA = 8'h28;

    // Flag bit positions inside {N,Z,V,C}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Memory map
    localparam logic [7:0] ROM_END   = 8'h7F;
    localparam logic [7:0] RAM_START = 8'h80;
    localparam logic [7:0] RAM_END   = 8'hDF;
    localparam logic [7:0] PORT_BASE = 8'hF0;

    typedef enum logic [3:0] {
        FETCH_A = 4'd0,
        FETCH_W = 4'd1,
        FETCH_D = 4'd2,
        DECODE  = 4'd3,
        OPR_A   = 4'd4,
        OPR_W   = 4'd5,
        OPR_D   = 4'd6,
        MEM_A   = 4'd7,
        MEM_W   = 4'd8,
        MEM_D   = 4'd9,
        ST      = 4'd10,
        HALT    = 4'd11
    } state_e;

    // PASS forwards b and refreshes N,Z only (used for loads)
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_INC  = 3'd5,
        ALU_DEC  = 3'd6
    } alu_op_e;

    function automatic logic is_alu_op(input logic [7:0] op);
        return op inside {[TOPLA_AB:AZALT_B]};
    endfunction

    // Opcodes that fetch a second (operand) byte
    function automatic logic is_operand_op(input logic [7:0] op);
        return (op inside {YUKLE_A_SBT, YUKLE_A, YUKLE_B_SBT, YUKLE_B, KAYDET_A, KAYDET_B})
            || (op inside {[ATLA:ATLA_ELDE_YOKSA]});
    endfunction

    function automatic alu_op_e alu_op_of(input logic [7:0] op);
        case (op)
            TOPLA_AB:          return ALU_ADD;
            CIKAR_AB:          return ALU_SUB;
            VE_AB:             return ALU_AND;
            VEYA_AB:           return ALU_OR;
            ARTIR_A, ARTIR_B:  return ALU_INC;
            AZALT_A, AZALT_B:  return ALU_DEC;
            default:           return ALU_PASS;
        endcase
    endfunction

    // Non-branch opcodes evaluate to 0, so callers may pass any opcode
    function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] f);
        case (op)
            ATLA:            return 1'b1;
            ATLA_N:          return f[FLAG_N];
            ATLA_N_DEGIL:    return !f[FLAG_N];
            ATLA_Z:          return f[FLAG_Z];
            ATLA_Z_DEGIL:    return !f[FLAG_Z];
            ATLA_V:          return f[FLAG_V];
            ATLA_V_DEGIL:    return !f[FLAG_V];
            ATLA_C:          return f[FLAG_C];
            ATLA_ELDE_YOKSA: return !f[FLAG_C];
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU.
// Ports: op (operation), a/b (operands), cin_flags (current {N,Z,V,C}),
//        result (8-bit, wraps mod 256), nzvc (updated {N,Z,V,C}).
// Flags an operation does not define are passed through from cin_flags.
module alu8
    import cpu_pkg::*;
(
    input  alu_op_e     op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [3:0]  cin_flags,
    output logic [7:0]  result,
    output logic [3:0]  nzvc
);

    logic [8:0] sum_s;

    // Result and flag computation for every ALU operation
    always_comb begin
        sum_s  = 9'd0;
        result = b;
        nzvc   = cin_flags;
        case (op)
            ALU_ADD: begin
                sum_s        = {1'b0, a} + {1'b0, b};
                result       = sum_s[7:0];
                nzvc[FLAG_C] = sum_s[8];
                // Same-sign operands producing an opposite-sign result
                nzvc[FLAG_V] = (a[7] == b[7]) && (result[7] != a[7]);
            end
            ALU_SUB: begin
                result       = a - b;
                nzvc[FLAG_C] = (a < b);
                nzvc[FLAG_V] = (a[7] != b[7]) && (result[7] != a[7]);
            end
            ALU_AND: begin
                result       = a & b;
                nzvc[FLAG_V] = 1'b0;
            end
            ALU_OR: begin
                result       = a | b;
                nzvc[FLAG_V] = 1'b0;
            end
            ALU_INC: begin
                result       = a + 8'd1;
                nzvc[FLAG_V] = (a == 8'h7F);
            end
            ALU_DEC: begin
                result       = a - 8'd1;
                nzvc[FLAG_V] = (a == 8'h80);
            end
            ALU_PASS: begin
                result = b;
            end
            default: begin
                result = b;
            end
        endcase
        nzvc[FLAG_N] = result[7];
        nzvc[FLAG_Z] = (result == 8'd0);
    end

endmodule

// File: rtl/decode_execute_unit.sv
// Multi-cycle decode/execute controller for the 8-bit CPU.
// Ports: clk (rising edge), rst (async, active-low), mem_data_in (byte from
//        the synchronous read mux), mem_addr / mem_data_out / mem_write (bus
//        and one-cycle RAM write strobe), pc, ir, reg_a, reg_b, flags {N,Z,V,C},
//        halted (illegal opcode seen, core stopped until reset).
// Every read is X_A (issue address) -> X_W (RD_WAIT cycles) -> X_D (sample).
// All outputs come straight from registers.
module decode_execute_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int          RD_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_write,
    output logic [7:0]  pc,
    output logic [7:0]  ir,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_b,
    output logic [3:0]  flags,
    output logic        halted
);

    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

    state_e      state_r, state_nxt_s;
    logic [7:0]  opr_r, opr_nxt_s;
    logic [3:0]  wait_r, wait_nxt_s;
    logic        wait_done_s;

    logic [7:0]  pc_nxt_s, ir_nxt_s, a_nxt_s, b_nxt_s, addr_nxt_s, dout_nxt_s;
    logic [3:0]  flags_nxt_s;
    logic        we_nxt_s, halted_nxt_s;

    alu_op_e     alu_op_s;
    logic [7:0]  alu_a_s, alu_b_s, alu_res_s;
    logic [3:0]  alu_nzvc_s;

    assign wait_done_s = (wait_r == WAIT_LAST);

    alu8 u_alu (
        .op        (alu_op_s),
        .a         (alu_a_s),
        .b         (alu_b_s),
        .cin_flags (flags),
        .result    (alu_res_s),
        .nzvc      (alu_nzvc_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= FETCH_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FETCH_A: state_nxt_s = FETCH_W;
            FETCH_W: state_nxt_s = wait_done_s ? FETCH_D : FETCH_W;
            FETCH_D: state_nxt_s = DECODE;
            DECODE: begin
                if (is_alu_op(ir)) begin
                    state_nxt_s = FETCH_A;
                end else if (is_operand_op(ir)) begin
                    state_nxt_s = OPR_A;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            OPR_A:   state_nxt_s = OPR_W;
            OPR_W:   state_nxt_s = wait_done_s ? OPR_D : OPR_W;
            OPR_D: begin
                case (ir)
                    YUKLE_A, YUKLE_B:   state_nxt_s = MEM_A;
                    KAYDET_A, KAYDET_B: state_nxt_s = ST;
                    default:            state_nxt_s = FETCH_A;
                endcase
            end
            MEM_A:   state_nxt_s = MEM_W;
            MEM_W:   state_nxt_s = wait_done_s ? MEM_D : MEM_W;
            MEM_D:   state_nxt_s = FETCH_A;
            ST:      state_nxt_s = FETCH_A;
            HALT:    state_nxt_s = HALT;
            default: state_nxt_s = FETCH_A;
        endcase
    end

    // ALU operand steering: register ops in DECODE, N/Z pass-through for loads
    always_comb begin
        alu_op_s = ALU_PASS;
        alu_a_s  = reg_a;
        alu_b_s  = mem_data_in;
        if (state_r == DECODE) begin
            alu_op_s = alu_op_of(ir);
            alu_b_s  = reg_b;
            if ((ir == ARTIR_B) || (ir == AZALT_B)) begin
                alu_a_s = reg_b;
            end else begin
                alu_a_s = reg_a;
            end
        end else begin
            alu_op_s = ALU_PASS;
        end
    end

    // Datapath next values for each state
    always_comb begin
        pc_nxt_s     = pc;
        ir_nxt_s     = ir;
        a_nxt_s      = reg_a;
        b_nxt_s      = reg_b;
        flags_nxt_s  = flags;
        addr_nxt_s   = mem_addr;
        dout_nxt_s   = mem_data_out;
        we_nxt_s     = 1'b0;
        halted_nxt_s = halted;
        opr_nxt_s    = opr_r;
        wait_nxt_s   = 4'd0;
        case (state_r)
            FETCH_A, OPR_A: addr_nxt_s = pc;
            MEM_A:          addr_nxt_s = opr_r;
            FETCH_W, OPR_W, MEM_W: wait_nxt_s = wait_done_s ? 4'd0 : (wait_r + 4'd1);
            FETCH_D: begin
                ir_nxt_s = mem_data_in;
                pc_nxt_s = pc + 8'd1;
            end
            DECODE: begin
                if (is_alu_op(ir)) begin
                    flags_nxt_s = alu_nzvc_s;
                    if ((ir == ARTIR_B) || (ir == AZALT_B)) begin
                        b_nxt_s = alu_res_s;
                    end else begin
                        a_nxt_s = alu_res_s;
                    end
                end else begin
                    halted_nxt_s = !is_operand_op(ir);
                end
            end
            OPR_D: begin
                // The operand is used straight off the bus so immediates,
                // branch targets and store addresses commit in this cycle.
                opr_nxt_s = mem_data_in;
                pc_nxt_s  = pc + 8'd1;
                case (ir)
                    YUKLE_A_SBT: begin
                        a_nxt_s     = mem_data_in;
                        flags_nxt_s = alu_nzvc_s;
                    end
                    YUKLE_B_SBT: begin
                        b_nxt_s     = mem_data_in;
                        flags_nxt_s = alu_nzvc_s;
                    end
                    KAYDET_A: begin
                        addr_nxt_s = mem_data_in;
                        dout_nxt_s = reg_a;
                        we_nxt_s   = 1'b1;
                    end
                    KAYDET_B: begin
                        addr_nxt_s = mem_data_in;
                        dout_nxt_s = reg_b;
                        we_nxt_s   = 1'b1;
                    end
                    default: begin
                        if (branch_taken(ir, flags)) begin
                            pc_nxt_s = mem_data_in;
                        end else begin
                            pc_nxt_s = pc + 8'd1;
                        end
                    end
                endcase
            end
            MEM_D: begin
                flags_nxt_s = alu_nzvc_s;
                if (ir == YUKLE_A) begin
                    a_nxt_s = mem_data_in;
                end else begin
                    b_nxt_s = mem_data_in;
                end
            end
            ST, HALT: we_nxt_s = 1'b0;
            default:  we_nxt_s = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            ir           <= 8'h00;
            reg_a        <= 8'h00;
            reg_b        <= 8'h00;
            flags        <= 4'b0000;
            mem_addr     <= 8'h00;
            mem_data_out <= 8'h00;
            mem_write    <= 1'b0;
            halted       <= 1'b0;
            opr_r        <= 8'h00;
            wait_r       <= 4'd0;
        end else begin
            pc           <= pc_nxt_s;
            ir           <= ir_nxt_s;
            reg_a        <= a_nxt_s;
            reg_b        <= b_nxt_s;
            flags        <= flags_nxt_s;
            mem_addr     <= addr_nxt_s;
            mem_data_out <= dout_nxt_s;
            mem_write    <= we_nxt_s;
            halted       <= halted_nxt_s;
            opr_r        <= opr_nxt_s;
            wait_r       <= wait_nxt_s;
        end
    end

endmodule

// File: tb/tb_decode_execute_unit.sv
// Scoreboard bench for decode_execute_unit: an instruction-level model
// predicts the architectural state after each instruction and every store
// pulse; a monitor compares these against the DUT as they appear.
module tb_decode_execute_unit;
    import cpu_pkg::*;

    logic       clk, rst;
    logic [7:0] mem_data_in, mem_addr, mem_data_out, pc, ir, reg_a, reg_b;
    logic       mem_write, halted;
    logic [3:0] flags;

    decode_execute_unit dut (
        .clk(clk), .rst(rst), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_write(mem_write), .pc(pc), .ir(ir),
        .reg_a(reg_a), .reg_b(reg_b), .flags(flags), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory system seen by the DUT: synchronous read, RAM-only writes
    logic [7:0] mem [256];
    logic [7:0] port_val [16];
    logic [7:0] rd_r;

    function automatic logic [7:0] bus_rd(input logic [7:0] a);
        if (a >= PORT_BASE) return port_val[a[3:0]];
        return mem[a];
    endfunction

    always @(posedge clk) begin
        rd_r <= bus_rd(mem_addr);
        if (mem_write && mem_addr >= RAM_START && mem_addr <= RAM_END)
            mem[mem_addr] <= mem_data_out;
    end
    assign mem_data_in = rd_r;

    // Scoreboard
    typedef struct packed {
        int         cyc;
        logic [7:0] pc, ir, a, b;
        logic [3:0] fl;
        logic       halted;
    } exp_t;
    typedef struct packed { logic [7:0] addr, data; } st_t;

    exp_t exp_q[$];
    st_t  st_q[$];
    int   n_vec = 0, n_err = 0;
    int   cyc;
    bit   mon_en = 1'b0;
    logic [7:0] m_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin : monitor
        st_t  s;
        exp_t e;
        if (mon_en && rst) begin
            if (mem_write) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_write", {31'd0, mem_write}, 32'd0);
                end else begin
                    s = st_q.pop_front();
                    chk("st_addr", {24'd0, mem_addr}, {24'd0, s.addr});
                    chk("st_data", {24'd0, mem_data_out}, {24'd0, s.data});
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("commit_cycle", cyc, e.cyc);
                chk("pc", {24'd0, pc}, {24'd0, e.pc});
                chk("ir", {24'd0, ir}, {24'd0, e.ir});
                chk("reg_a", {24'd0, reg_a}, {24'd0, e.a});
                chk("reg_b", {24'd0, reg_b}, {24'd0, e.b});
                chk("flags", {28'd0, flags}, {28'd0, e.fl});
                chk("halted", {31'd0, halted}, {31'd0, e.halted});
            end
        end
    end

    // Instruction-level reference model
    function automatic int m_rd(input int ad);
        if (ad >= int'(PORT_BASE)) return int'(port_val[ad - int'(PORT_BASE)]);
        return int'(m_mem[ad]);
    endfunction

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic model_run(input int max_instr);
        int p, a, b, n, z, v, c, t, op, opr, r, s, dst_b;
        bit halt, take;
        exp_t e;
        p = 0; a = 0; b = 0; n = 0; z = 0; v = 0; c = 0; t = 0; halt = 1'b0;
        for (int i = 0; i < max_instr && !halt; i++) begin
            op = m_rd(p);
            p  = (p + 1) % 256;
            case (op)
                8'h86, 8'h88, 8'h87, 8'h89: begin
                    opr = m_rd(p); p = (p + 1) % 256;
                    r = (op == 8'h87 || op == 8'h89) ? m_rd(opr) : opr;
                    if (op == 8'h86 || op == 8'h87) a = r; else b = r;
                    n = r / 128; z = (r == 0);
                    t += (op == 8'h87 || op == 8'h89) ? 10 : 7;
                end
                8'h96, 8'h97: begin
                    opr = m_rd(p); p = (p + 1) % 256;
                    r = (op == 8'h96) ? a : b;
                    st_q.push_back('{addr: 8'(opr), data: 8'(r)});
                    if (opr >= int'(RAM_START) && opr <= int'(RAM_END)) m_mem[opr] = 8'(r);
                    t += 8;
                end
                8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49: begin
                    dst_b = (op == 8'h47 || op == 8'h49);
                    case (op)
                        8'h42: begin s = sgn(a) + sgn(b); v = (s > 127 || s < -128); c = (a + b > 255); r = (a + b) % 256; end
                        8'h43: begin s = sgn(a) - sgn(b); v = (s > 127 || s < -128); c = (a < b); r = (a - b + 256) % 256; end
                        8'h44: begin r = a & b; v = 0; end
                        8'h45: begin r = a | b; v = 0; end
                        8'h46, 8'h47: begin s = dst_b ? b : a; v = (sgn(s) + 1 > 127); r = (s + 1) % 256; end
                        default: begin s = dst_b ? b : a; v = (sgn(s) - 1 < -128); r = (s + 255) % 256; end
                    endcase
                    if (dst_b) b = r; else a = r;
                    n = r / 128; z = (r == 0);
                    t += 4;
                end
                8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28: begin
                    opr = m_rd(p); p = (p + 1) % 256;
                    case (op)
                        8'h20: take = 1'b1;
                        8'h21: take = (n == 1); 8'h22: take = (n == 0);
                        8'h23: take = (z == 1); 8'h24: take = (z == 0);
                        8'h25: take = (v == 1); 8'h26: take = (v == 0);
                        8'h27: take = (c == 1); default: take = (c == 0);
                    endcase
                    if (take) p = opr;
                    t += 7;
                end
                default: begin
                    halt = 1'b1;
                    t += 4;
                end
            endcase
            e.cyc = t; e.pc = 8'(p); e.ir = 8'(op); e.a = 8'(a); e.b = 8'(b);
            e.fl = {n[0], z[0], v[0], c[0]}; e.halted = halt;
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic gen_prog();
        int pos, k;
        int starts[$];
        int br_pos[$];
        clear_mem();
        for (int i = int'(RAM_START); i <= int'(RAM_END); i++) mem[i] = 8'($urandom_range(0, 255));
        pos = 0;
        while (pos < int'(ROM_END) - 3) begin
            starts.push_back(pos);
            k = $urandom_range(0, 99);
            if (k < 30) begin
                mem[pos] = 8'(8'h42 + $urandom_range(0, 7)); pos += 1;
            end else if (k < 45) begin
                mem[pos] = ($urandom_range(0, 1) == 0) ? 8'h86 : 8'h88;
                mem[pos + 1] = 8'($urandom_range(0, 255)); pos += 2;
            end else if (k < 58) begin
                mem[pos] = ($urandom_range(0, 1) == 0) ? 8'h87 : 8'h89;
                mem[pos + 1] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(128, 223))
                                                           : 8'($urandom_range(240, 255));
                pos += 2;
            end else if (k < 72) begin
                mem[pos] = ($urandom_range(0, 1) == 0) ? 8'h96 : 8'h97;
                mem[pos + 1] = 8'($urandom_range(0, 255)); pos += 2;
            end else if (k < 97) begin
                mem[pos] = 8'(8'h20 + $urandom_range(0, 8));
                br_pos.push_back(pos + 1); pos += 2;
            end else begin
                mem[pos] = 8'hFF; pos += 1;
            end
        end
        mem[pos] = 8'h20;
        mem[pos + 1] = 8'h00;
        foreach (br_pos[i]) mem[br_pos[i]] = 8'(starts[$urandom_range(0, starts.size() - 1)]);
    endtask

    // Reset, check the cleared state, predict, then release at a falling edge
    task automatic start_prog(input bit use_mon, input int max_instr);
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_pc", {24'd0, pc}, 32'h00);
        chk("rst_ir", {24'd0, ir}, 32'h00);
        chk("rst_a", {24'd0, reg_a}, 32'h00);
        chk("rst_b", {24'd0, reg_b}, 32'h00);
        chk("rst_flags", {28'd0, flags}, 32'h0);
        chk("rst_addr", {24'd0, mem_addr}, 32'h00);
        chk("rst_dout", {24'd0, mem_data_out}, 32'h00);
        chk("rst_we", {31'd0, mem_write}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
        exp_q.delete();
        st_q.delete();
        if (use_mon) model_run(max_instr);
        mon_en = use_mon;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic finish_prog();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 4000) begin
            @(posedge clk);
            budget++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
        chk("stores_left", st_q.size(), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : stim
        int bad, w;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) port_val[i] = 8'($urandom_range(0, 255));
        port_val[14] = 8'h86;
        port_val[15] = 8'h46;

        // ALU commit timing and values
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h86, 8'h05, 8'h88, 8'h03, 8'h42, 8'hFF};
        start_prog(1'b1, 10);
        repeat (17) @(posedge clk);
        #1 chk("a_before_commit", {24'd0, reg_a}, 32'h05);
        @(posedge clk);
        #1 chk("a_at_cycle18", {24'd0, reg_a}, 32'h08);
        chk("b_at_cycle18", {24'd0, reg_b}, 32'h03);
        chk("flags_at_cycle18", {28'd0, flags}, 32'h0);
        finish_prog();

        // INC overflow, then ADD carry to zero
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8]} =
            {8'h86, 8'h7F, 8'h46, 8'h88, 8'hFF, 8'h86, 8'h01, 8'h42, 8'hFF};
        start_prog(1'b1, 10);
        finish_prog();

        // Store then direct load back
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} =
            {8'h86, 8'hAA, 8'h96, 8'h90, 8'h89, 8'h90, 8'hFF};
        start_prog(1'b1, 10);
        finish_prog();
        chk("ram_90", {24'd0, mem[8'h90]}, 32'hAA);

        // Taken and not-taken branches
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3]} = {8'h86, 8'h00, 8'h23, 8'h40};
        {mem[8'h40], mem[8'h41], mem[8'h42]} = {8'h24, 8'h00, 8'hFF};
        start_prog(1'b1, 10);
        finish_prog();

        // Illegal opcode: stays halted, never writes, then reset recovers
        clear_mem();
        mem[0] = 8'hFF;
        start_prog(1'b1, 5);
        finish_prog();
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (!halted || mem_write) bad++;
        end
        chk("halt_hold", bad, 32'd0);
        chk("halt_addr", {24'd0, mem_addr}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("halt_rst_pc", {24'd0, pc}, 32'h00);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);

        // Reset asserted during the store cycle
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h86, 8'h5A, 8'h96, 8'hA0, 8'h20, 8'h00};
        mem[8'hA0] = 8'h33;
        start_prog(1'b0, 0);
        w = 0;
        while (!mem_write && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("store_seen", {31'd0, mem_write}, 32'd1);
        #1 rst = 1'b0;
        #1 chk("store_abort", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1 chk("ram_unchanged", {24'd0, mem[8'hA0]}, 32'h33);

        // PC wrap on operand fetch (FE/FF) and on opcode fetch (FF)
        clear_mem();
        {mem[0], mem[1]} = {8'h20, 8'hFE};
        start_prog(1'b1, 6);
        finish_prog();
        clear_mem();
        {mem[0], mem[1]} = {8'h20, 8'hFF};
        start_prog(1'b1, 6);
        finish_prog();

        // Random programs
        for (int r = 0; r < 8; r++) begin
            gen_prog();
            start_prog(1'b1, 150);
            finish_prog();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_execute_unit.md
Name: decode_execute_unit

Overview:
- Multi-cycle decode/execute controller for the 8-bit CPU. Sits directly downstream of the fetch/memory-mux stage and consumes its data_out byte stream.
- Owns PC, IR, accumulators A/B and condition flags NZVC.
- Drives the memory address bus (ROM 00-7F, RAM 80-DF, input ports F0-FF) and the RAM write path.
- Executes the load/store, ALU and branch instruction set.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- RD_WAIT, 1, wait states between address issue and data sample. The memory read is synchronous, so the value is 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_data_in  in  8  byte returned by the fetch-stage read mux.
- mem_addr  out  8  registered memory/port address.
- mem_data_out  out  8  write data for RAM.
- mem_write  out  1  one-cycle RAM write strobe.
- pc  out  8  program counter.
- ir  out  8  current opcode.
- reg_a  out  8  accumulator A.
- reg_b  out  8  accumulator B.
- flags  out  4  {N,Z,V,C}.
- halted  out  1  illegal opcode seen; core stopped.

Behaviour:
- Reset: while rst=0, asynchronously clear the following, regardless of state or cycle:
  - pc=RESET_PC; ir, reg_a, reg_b, mem_addr, mem_data_out = 00; flags=0000; mem_write=0; halted=0; state=FETCH_A.
  - An in-flight mem_write drops immediately.
- Read timing: mem_addr is issued in state X_A. The X_W state spends RD_WAIT cycles. mem_data_in is sampled at the end of state X_D.
- State sequence:
  - FETCH_A -> FETCH_W -> FETCH_D (ir<=data, pc<=pc+1) -> DECODE.
  - DECODE, ALU ops (42-49): result and flags commit at the end of DECODE -> FETCH_A. Total 4 cycles.
  - DECODE, 2-byte ops (86-89, 96-97, 20-28): OPR_A (mem_addr<=pc) -> OPR_W -> OPR_D (opr<=data, pc<=pc+1) -> dispatch.
  - Immediate load 86/88: reg<=opr at the end of OPR_D -> FETCH_A. Total 7 cycles.
  - Direct load 87/89: MEM_A (mem_addr<=opr) -> MEM_W -> MEM_D (reg<=data) -> FETCH_A. Total 10 cycles.
  - Store 96/97: ST state, mem_addr<=opr, mem_data_out<=reg, mem_write=1 for exactly one cycle -> FETCH_A. Total 8 cycles.
  - Branches 20-28: if the condition holds, pc<=opr at the end of OPR_D; otherwise pc keeps its incremented value -> FETCH_A. Total 7 cycles.
  - Any other opcode: HALT with halted=1. The state is terminal until reset. mem_write=0, mem_addr held.
- Opcodes:
  - 86 A<=#imm, 87 A<=[addr], 88 B<=#imm, 89 B<=[addr], 96 [addr]<=A, 97 [addr]<=B.
  - 42 A<=A+B, 43 A<=A-B, 44 A<=A&B, 45 A<=A|B.
  - 46 A+1, 47 B+1, 48 A-1, 49 B-1.
  - 20 always, 21 N, 22 !N, 23 Z, 24 !Z, 25 V, 26 !V, 27 C, 28 !C.
- Flags:
  - All arithmetic is 8-bit; results wrap mod 256.
  - Loads: update N,Z. V and C unchanged.
  - ADD: C=carry out of bit 7; V=signed overflow.
  - SUB: C=borrow (A<B unsigned); V=signed overflow.
  - AND/OR: N,Z updated; V=0; C unchanged.
  - INC/DEC: N,Z,V updated (V on 7F->80 or 80->7F); C unchanged.
  - Stores and branches leave flags unchanged.
- Boundaries:
  - pc wraps FF->00, both on the opcode fetch and on the operand fetch.
  - A store to a non-RAM address (00-7F or E0-FF) still pulses mem_write; the memory decides whether to accept it.
  - A direct load from F0-FF returns port data with no extra wait.
  - A branch target may be any value, including its own address (tight loop).

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (YUKLE_A_SBT, YUKLE_A, YUKLE_B_SBT, YUKLE_B, KAYDET_A, KAYDET_B, TOPLA_AB ... ATLA_ELDE_YOKSA);
  - the state enum;
  - flag bit indices;
  - address-region bounds (ROM_END=7F, RAM_START=80, RAM_END=DF, PORT_BASE=F0).
- One combinational sub-module, alu8, takes op, a, b, cin_flags and returns result and nzvc. The FSM, PC and register file stay in the top.

Test Plan:
- ROM at 00: 86 05, 88 03, 42 -> A=08, B=03, flags N0 Z0 V0 C0. The ALU commit lands exactly 18 cycles after reset release.
- 86 7F, 46 -> A=80, N=1, V=1, C unchanged. Then 88 FF, 86 01, 42 -> A=00, Z=1, C=1.
- 86 AA, 96 90, 89 90 -> one-cycle mem_write pulse with addr=90, data=AA. B=AA, N=1.
- 86 00, 23 40 -> pc=40 after the branch. Then at 40: 24 00 -> not taken, pc=42.
- Opcode FF fetched -> halted=1, state stays HALT for 20+ cycles, mem_write never asserts. Then rst=0 -> pc=00, halted=0.
- Assert rst=0 during a store's ST cycle -> mem_write falls in the same cycle without waiting for a clock edge, and RAM is unchanged.
